// File: rtl/sgd_pkg.sv
// Shared types and constants for the mini-batch gradient accumulator.
// Exports lane/chunk types, the FSM state enum and the chunk-count helper.
package sgd_pkg;

    localparam int LANES    = 8;
    localparam int ADDR_W   = 9;
    localparam int CHUNK_SH = 6;
    localparam int DEPTH    = 2 ** ADDR_W;

    typedef logic signed [31:0] lane_t;
    typedef lane_t [LANES-1:0] chunk_t;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        ACCUM,
        DRAIN
    } acc_state_e;

    // Index of the last chunk for a feature count: ceil(dim/2**CHUNK_SH)-1.
    // At least one chunk is always used, and the count is capped at the
    // accumulator depth so the address counter can never run off the end.
    function automatic logic [ADDR_W-1:0] chunk_last(input logic [31:0] dim);
        logic [32:0] n;
        n = ({1'b0, dim} + 33'(2 ** CHUNK_SH - 1)) >> CHUNK_SH;
        if (n == 33'd0) return '0;
        if (n > 33'(DEPTH)) return ADDR_W'(DEPTH - 1);
        return ADDR_W'(n - 33'd1);
    endfunction

endpackage

// File: rtl/sgd_acc_mem.sv
// Accumulator storage: 2**ADDR_W chunks, asynchronous read, synchronous write.
// Ports: clk, we/addr/wdata (single write port), rdata (read of addr).
module sgd_acc_mem
    import sgd_pkg::*;
(
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [LANES*32-1:0]   wdata,
    output logic [LANES*32-1:0]   rdata
);

    chunk_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/sgd_acc_gradient_gen.sv
// Sums per-sample gradient chunks over a mini-batch and drains acc >>> step.
// Ports: clk, rst, started, dimension, mini_batch_size, step_size,
//        grad/grad_valid/grad_ready (input chunk handshake),
//        acc_gradient/acc_gradient_valid (drain), batch_counter (debug).
module sgd_acc_gradient_gen
    import sgd_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  started,
    input  logic [31:0]           dimension,
    input  logic [31:0]           mini_batch_size,
    input  logic [4:0]            step_size,
    input  logic [LANES*32-1:0]   grad,
    input  logic                  grad_valid,
    output logic                  grad_ready,
    output logic [LANES*32-1:0]   acc_gradient,
    output logic [LANES-1:0]      acc_gradient_valid,
    output logic [31:0]           batch_counter
);

    acc_state_e        state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] n_last;
    logic [31:0]       mb_last;
    logic [31:0]       samples;
    logic [4:0]        step;

    logic   accept;
    logic   we;
    chunk_t grad_c;
    chunk_t rdata;
    chunk_t wdata;
    chunk_t sum;
    chunk_t shifted;

    assign grad_c     = grad;
    assign grad_ready = (state == ACCUM);
    assign accept     = grad_ready && grad_valid;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            sum[i]     = rdata[i] + grad_c[i];
            shifted[i] = rdata[i] >>> step;
        end
    end

    // One address counter serves CLEAR, ACCUM and DRAIN; CLEAR and DRAIN
    // both write zero, ACCUM writes the read-modify sum of the same entry.
    assign we    = (state == CLEAR) || (state == DRAIN) || accept;
    assign wdata = (state == ACCUM) ? sum : '0;

    sgd_acc_mem u_mem (
        .clk   (clk),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            addr               <= '0;
            n_last             <= '0;
            mb_last            <= '0;
            samples            <= '0;
            step               <= '0;
            acc_gradient       <= '0;
            acc_gradient_valid <= '0;
            batch_counter      <= '0;
        end else begin
            acc_gradient_valid <= '0;
            unique case (state)
                IDLE: begin
                    if (started) begin
                        state   <= CLEAR;
                        addr    <= '0;
                        samples <= '0;
                        n_last  <= chunk_last(dimension);
                        mb_last <= (mini_batch_size == 32'd0) ? 32'd0
                                 : mini_batch_size - 32'd1;
                        step    <= step_size;
                    end
                end
                CLEAR: begin
                    if (!started) begin
                        state <= IDLE;
                    end else if (addr == n_last) begin
                        addr  <= '0;
                        state <= ACCUM;
                    end else begin
                        addr <= addr + 1'b1;
                    end
                end
                ACCUM: begin
                    if (!started) begin
                        state <= IDLE;
                    end else if (accept) begin
                        if (addr == n_last) begin
                            addr <= '0;
                            if (samples == mb_last) begin
                                samples <= '0;
                                state   <= DRAIN;
                            end else begin
                                samples <= samples + 32'd1;
                            end
                        end else begin
                            addr <= addr + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    acc_gradient       <= shifted;
                    acc_gradient_valid <= '1;
                    if (addr == n_last) begin
                        addr          <= '0;
                        batch_counter <= batch_counter + 32'd1;
                        state         <= started ? ACCUM : IDLE;
                    end else begin
                        addr <= addr + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sgd_acc_gradient_gen.sv
// Self-checking bench for sgd_acc_gradient_gen: vector table, corner
// sequences and randomized multi-batch jobs against a sum/shift model.
module tb_sgd_acc_gradient_gen;

    logic         clk = 1'b0;
    logic         rst;
    logic         started;
    logic [31:0]  dimension;
    logic [31:0]  mini_batch_size;
    logic [4:0]   step_size;
    logic [255:0] grad;
    logic         grad_valid;
    logic         grad_ready;
    logic [255:0] acc_gradient;
    logic [7:0]   acc_gradient_valid;
    logic [31:0]  batch_counter;

    sgd_acc_gradient_gen dut (
        .clk                (clk),
        .rst                (rst),
        .started            (started),
        .dimension          (dimension),
        .mini_batch_size    (mini_batch_size),
        .step_size          (step_size),
        .grad               (grad),
        .grad_valid         (grad_valid),
        .grad_ready         (grad_ready),
        .acc_gradient       (acc_gradient),
        .acc_gradient_valid (acc_gradient_valid),
        .batch_counter      (batch_counter)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc_cyc = 0;
    int lane_err = 0;
    int bc_exp = 0;
    logic [255:0] out_q[$];
    int cyc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (acc_gradient_valid != 8'h00) begin
            out_q.push_back(acc_gradient);
            cyc_q.push_back(cyc);
            if (acc_gradient_valid != 8'hFF) lane_err++;
        end
    end

    typedef struct {
        int dim;
        int nsamp;
        int mb;
        int st;
        int g0;
        int g1;
        int ginc;
        int n;
        int e0;
        int einc;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [255:0] act,
                         input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] mk(input int base, input int inc);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = base + i * inc;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int dim, input int mb, input int st);
        dimension       = dim;
        mini_batch_size = mb;
        step_size       = 5'(st);
        started         = 1'b1;
    endtask

    task automatic send(input logic [255:0] ch, output int waited);
        grad       = ch;
        grad_valid = 1'b1;
        waited     = 0;
        while (!grad_ready && waited < 100) begin
            tick();
            waited++;
        end
        if (!grad_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got ready=0 expected ready=1");
            grad_valid = 1'b0;
            return;
        end
        tick();
        grad_valid   = 1'b0;
        last_acc_cyc = cyc;
    endtask

    task automatic wait_outputs(input int n, input string name);
        int b;
        b = 0;
        while (out_q.size() < n && b < 200) begin
            tick();
            b++;
        end
        checks++;
        if (out_q.size() < n) begin
            errors++;
            $display("FAIL %s_timeout got %0d outputs expected %0d",
                     name, out_q.size(), n);
        end
        repeat (3) tick();
    endtask

    initial begin
        int w;
        int dim, n, mb, st, nb;
        int sums [8][8];
        logic [255:0] exp_q[$];
        logic [255:0] e;

        tbl[0] = '{128, 2, 2, 0, 1, 1, 1, 2, 2, 2};
        tbl[1] = '{1, 3, 3, 1, 4, 4, 0, 1, 6, 0};
        tbl[2] = '{1, 2, 2, 2, -8, -8, 0, 1, -4, 0};
        tbl[3] = '{1, 2, 2, 0, 32'h7FFFFFFF, 1, 0, 1, 32'h80000000, 0};
        tbl[4] = '{65, 1, 0, 3, 80, 80, 0, 2, 10, 0};
        tbl[5] = '{64, 1, 1, 31, -1, -1, 0, 1, -1, 0};
        tbl[6] = '{129, 2, 2, 1, 10, -4, 1, 3, 3, 1};

        rst = 1'b1;
        started = 1'b0;
        dimension = '0;
        mini_batch_size = '0;
        step_size = '0;
        grad = '0;
        grad_valid = 1'b0;
        repeat (2) tick();
        check("rst_ready", 256'(grad_ready), 256'(0));
        check("rst_acc", acc_gradient, 256'(0));
        check("rst_valid", 256'(acc_gradient_valid), 256'(0));
        check("rst_bc", 256'(batch_counter), 256'(0));
        rst = 1'b0;
        repeat (2) tick();

        for (int k = 0; k < 7; k++) begin
            out_q.delete();
            cyc_q.delete();
            start_job(tbl[k].dim, tbl[k].mb, tbl[k].st);
            for (int s = 0; s < tbl[k].nsamp; s++)
                for (int c = 0; c < tbl[k].n; c++)
                    send(mk((s == 0) ? tbl[k].g0 : tbl[k].g1, tbl[k].ginc), w);
            started = 1'b0;
            wait_outputs(tbl[k].n, $sformatf("tbl%0d", k));
            check($sformatf("tbl%0d_count", k), 256'(out_q.size()),
                  256'(tbl[k].n));
            e = mk(tbl[k].e0, tbl[k].einc);
            for (int c = 0; c < out_q.size(); c++)
                check($sformatf("tbl%0d_chunk%0d", k, c), out_q[c], e);
            if (out_q.size() > 0) begin
                check($sformatf("tbl%0d_latency", k), 256'(cyc_q[0]),
                      256'(last_acc_cyc + 1));
                check($sformatf("tbl%0d_span", k),
                      256'(cyc_q[cyc_q.size()-1] - cyc_q[0]),
                      256'(tbl[k].n - 1));
            end
            check($sformatf("tbl%0d_hold", k), acc_gradient, e);
            bc_exp++;
            check($sformatf("tbl%0d_bc", k), 256'(batch_counter),
                  256'(bc_exp));
            check($sformatf("tbl%0d_idle", k), 256'(grad_ready), 256'(0));
        end

        out_q.delete();
        cyc_q.delete();
        start_job(128, 2, 0);
        for (int c = 0; c < 3; c++) send(mk(100, 0), w);
        started = 1'b0;
        repeat (5) tick();
        check("stop_no_valid", 256'(out_q.size()), 256'(0));
        check("stop_idle", 256'(grad_ready), 256'(0));
        check("stop_bc", 256'(batch_counter), 256'(bc_exp));
        start_job(128, 2, 0);
        for (int c = 0; c < 4; c++) send(mk(1, 1), w);
        started = 1'b0;
        wait_outputs(2, "restart");
        check("restart_count", 256'(out_q.size()), 256'(2));
        for (int c = 0; c < out_q.size(); c++)
            check($sformatf("restart_chunk%0d", c), out_q[c], mk(2, 2));
        bc_exp++;
        check("restart_bc", 256'(batch_counter), 256'(bc_exp));

        for (int j = 0; j < 6; j++) begin
            dim = $urandom_range(1, 320);
            n   = (dim + 63) / 64;
            mb  = $urandom_range(1, 3);
            st  = (j % 2 == 1) ? $urandom_range(0, 31) : $urandom_range(0, 3);
            nb  = 2;
            out_q.delete();
            cyc_q.delete();
            exp_q.delete();
            start_job(dim, mb, st);
            for (int b = 0; b < nb; b++) begin
                sums = '{default: 0};
                for (int s = 0; s < mb; s++) begin
                    for (int c = 0; c < n; c++) begin
                        for (int i = 0; i < 8; i++) e[i*32 +: 32] = $urandom();
                        for (int i = 0; i < 8; i++)
                            sums[c][i] = sums[c][i] + int'(e[i*32 +: 32]);
                        if (b > 0 && s == 0 && c == 0) begin
                            send(e, w);
                            check($sformatf("rnd%0d_bp_wait", j),
                                  256'(w), 256'(n));
                        end else begin
                            repeat ($urandom_range(0, 2)) tick();
                            send(e, w);
                        end
                    end
                end
                for (int c = 0; c < n; c++) begin
                    for (int i = 0; i < 8; i++)
                        e[i*32 +: 32] = sums[c][i] >>> st;
                    exp_q.push_back(e);
                end
            end
            started = 1'b0;
            wait_outputs(nb * n, $sformatf("rnd%0d", j));
            check($sformatf("rnd%0d_count", j), 256'(out_q.size()),
                  256'(nb * n));
            for (int c = 0; c < exp_q.size() && c < out_q.size(); c++)
                check($sformatf("rnd%0d_chunk%0d", j, c), out_q[c], exp_q[c]);
            bc_exp += nb;
            check($sformatf("rnd%0d_bc", j), 256'(batch_counter),
                  256'(bc_exp));
        end

        check("valid_lanes", 256'(lane_err), 256'(0));

        out_q.delete();
        start_job(128, 2, 0);
        send(mk(7, 0), w);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_ready", 256'(grad_ready), 256'(0));
        check("midrst_acc", acc_gradient, 256'(0));
        check("midrst_valid", 256'(acc_gradient_valid), 256'(0));
        check("midrst_bc", 256'(batch_counter), 256'(0));
        started = 1'b0;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check("midrst_idle", 256'(grad_ready), 256'(0));
        check("midrst_no_valid", 256'(out_q.size()), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

endmodule
